// File: rtl/uart_cmd_ctrl.sv
// Command/response controller between the UART and the host command logic.
// Assembles 3-byte commands from received bytes and serialises 1- or 2-byte replies.
module uart_cmd_ctrl #(
  parameter logic [7:0]  ACK_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT  = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rdy,
  output logic        clr_rdy,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frame_err,
  input  logic [15:0] resp_data,
  input  logic        send_resp,
  input  logic        send_ack,
  output logic        resp_busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StSend, StGuard, StWait} tx_state_e;

  logic [1:0]      rx_cnt;
  logic [CntW-1:0] idle_cnt;
  logic            accept;

  tx_state_e       tx_state;
  logic [1:0]      tx_cnt;
  logic [7:0]      resp_lo;

  // clr_rdy qualifier stops the still-high rdy from being captured twice
  assign accept = rdy && !clr_rdy && !cmd_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_rdy   <= 1'b0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      frame_err <= 1'b0;
      rx_cnt    <= '0;
      idle_cnt  <= '0;
    end else begin
      clr_rdy   <= accept;
      frame_err <= 1'b0;
      if (cmd_rdy && clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
      if (accept) begin
        idle_cnt <= '0;
        case (rx_cnt)
          2'd0:    cmd[23:16] <= rx_data;
          2'd1:    cmd[15:8]  <= rx_data;
          default: cmd[7:0]   <= rx_data;
        endcase
        if (rx_cnt == 2'd2) begin
          rx_cnt  <= '0;
          cmd_rdy <= 1'b1;
        end else begin
          rx_cnt <= rx_cnt + 2'd1;
        end
      end else if (rx_cnt != 2'd0) begin
        if (idle_cnt == CntW'(TIMEOUT)) begin
          rx_cnt    <= '0;
          idle_cnt  <= '0;
          frame_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + CntW'(1);
        end
      end
    end
  end

  // StSend is the cycle trmt is high; StGuard masks the UART's stale tx_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= StIdle;
      tx_cnt    <= '0;
      tx_data   <= '0;
      resp_lo   <= '0;
      trmt      <= 1'b0;
      resp_busy <= 1'b0;
    end else begin
      trmt <= 1'b0;
      case (tx_state)
        StIdle: begin
          if (send_resp) begin
            resp_lo   <= resp_data[7:0];
            tx_data   <= resp_data[15:8];
            tx_cnt    <= 2'd2;
            resp_busy <= 1'b1;
            trmt      <= 1'b1;
            tx_state  <= StSend;
          end else if (send_ack) begin
            tx_data  <= ACK_BYTE;
            tx_cnt   <= 2'd1;
            trmt     <= 1'b1;
            tx_state <= StSend;
          end
        end
        StSend:  tx_state <= StGuard;
        StGuard: tx_state <= StWait;
        StWait: begin
          if (tx_done) begin
            tx_cnt <= tx_cnt - 2'd1;
            if (tx_cnt == 2'd2) begin
              tx_data  <= resp_lo;
              trmt     <= 1'b1;
              tx_state <= StSend;
            end else begin
              resp_busy <= 1'b0;
              tx_state  <= StIdle;
            end
          end
        end
        default: tx_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a small behavioural UART on both sides.
module tb_uart_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rdy = 1'b0;
  logic        clr_rdy;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done = 1'b0;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        frame_err;
  logic [15:0] resp_data = '0;
  logic        send_resp = 1'b0;
  logic        send_ack = 1'b0;
  logic        resp_busy;

  int n_vec = 0;
  int n_err = 0;
  int clr_cnt = 0;
  int ferr_cnt = 0;
  int trmt_cnt = 0;
  int cd = 0;

  uart_cmd_ctrl #(
    .ACK_BYTE (8'hA5),
    .TIMEOUT  (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rdy         (rdy),
    .clr_rdy     (clr_rdy),
    .tx_data     (tx_data),
    .trmt        (trmt),
    .tx_done     (tx_done),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .frame_err   (frame_err),
    .resp_data   (resp_data),
    .send_resp   (send_resp),
    .send_ack    (send_ack),
    .resp_busy   (resp_busy)
  );

  always #5 clk = ~clk;

  // UART transmitter model: tx_done drops on trmt and returns 8 cycles later
  always @(negedge clk) begin
    clr_cnt  += int'(clr_rdy);
    ferr_cnt += int'(frame_err);
    if (trmt) begin
      trmt_cnt++;
      tx_done = 1'b0;
      cd = 8;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) tx_done = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    rx_data = b;
    rdy = 1'b1;
  endtask

  task automatic wait_consumed();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (clr_rdy) begin
        ok = 1'b1;
        rdy = 1'b0;
        break;
      end
    end
    check("byte_consumed", {31'd0, ok}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    put_byte(b);
    wait_consumed();
  endtask

  task automatic pulse_clr_cmd();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic wait_trmt(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (trmt) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!resp_busy) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    int base;
    int gap;

    #1;
    check("reset_outputs", {trmt, clr_rdy, tx_data, cmd, cmd_rdy, frame_err, resp_busy}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // three-byte frame
    base = clr_cnt;
    send_byte(8'h12);
    send_byte(8'h34);
    check("cmd_rdy_early", {31'd0, cmd_rdy}, 32'd0);
    send_byte(8'h56);
    check("cmd_rdy_rise", {31'd0, cmd_rdy}, 32'd1);
    check("cmd_frame1", cmd, 32'h123456);
    tick();
    check("clr_rdy_pulses", clr_cnt - base, 32'd3);
    check("no_frame_err", ferr_cnt, 32'd0);

    // fourth byte waits while cmd_rdy is held
    base = clr_cnt;
    put_byte(8'h78);
    repeat (6) tick();
    check("held_no_clr_rdy", clr_cnt - base, 32'd0);
    check("held_cmd_stable", cmd, 32'h123456);
    pulse_clr_cmd();
    check("cmd_rdy_cleared", {31'd0, cmd_rdy}, 32'd0);
    check("wait_one_edge", {31'd0, clr_rdy}, 32'd0);
    wait_consumed();
    send_byte(8'h9A);
    send_byte(8'hBC);
    check("cmd_frame2", cmd, 32'h789ABC);
    check("cmd_rdy_frame2", {31'd0, cmd_rdy}, 32'd1);
    pulse_clr_cmd();

    // inter-byte timeout
    base = ferr_cnt;
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (70) tick();
    check("timeout_pulse", ferr_cnt - base, 32'd1);
    check("timeout_cmd_kept", cmd, 32'h1122BC);
    check("timeout_no_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    check("cmd_after_timeout", cmd, 32'hAABBCC);
    pulse_clr_cmd();

    // two-byte response
    base = trmt_cnt;
    resp_data = 16'hBEEF;
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    check("resp_trmt1", {31'd0, trmt}, 32'd1);
    check("resp_busy_rise", {31'd0, resp_busy}, 32'd1);
    check("resp_byte_hi", tx_data, 32'hBE);
    wait_trmt(gap);
    check("resp_gap", gap, 32'd9);
    check("resp_byte_lo", tx_data, 32'hEF);
    wait_idle(gap);
    check("resp_busy_fall", gap, 32'd9);
    check("resp_trmt_count", trmt_cnt - base, 32'd2);

    // simultaneous requests: response wins, ack dropped
    base = trmt_cnt;
    resp_data = 16'h1234;
    send_resp = 1'b1;
    send_ack = 1'b1;
    tick();
    send_resp = 1'b0;
    send_ack = 1'b0;
    check("both_byte_hi", tx_data, 32'h12);
    wait_trmt(gap);
    check("both_byte_lo", tx_data, 32'h34);
    send_ack = 1'b1;
    tick();
    send_ack = 1'b0;
    wait_idle(gap);
    check("both_busy_fall", gap, 32'd8);
    repeat (12) tick();
    check("ack_dropped", trmt_cnt - base, 32'd2);

    // plain acknowledge
    send_ack = 1'b1;
    tick();
    send_ack = 1'b0;
    check("ack_trmt", {31'd0, trmt}, 32'd1);
    check("ack_byte", tx_data, 32'hA5);
    repeat (15) tick();
    check("ack_single", trmt_cnt - base, 32'd3);
    check("tx_data_hold", tx_data, 32'hA5);

    // reset mid-frame and mid-transmit
    send_byte(8'h55);
    resp_data = 16'hCAFE;
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    repeat (3) tick();
    check("pre_reset_busy", {31'd0, resp_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset", {trmt, clr_rdy, tx_data, cmd, cmd_rdy, frame_err, resp_busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    base = trmt_cnt;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    check("cmd_after_reset", cmd, 32'h010203);
    check("cmd_rdy_after_reset", {31'd0, cmd_rdy}, 32'd1);
    repeat (20) tick();
    check("resp_lost", trmt_cnt - base, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
